// File: rtl/sct_arbiter.sv
// N-channel grant arbiter with fixed-priority or round-robin selection,
// bounded hold time and a saturating timeout counter.
module sct_arbiter #(
  parameter int N        = 5,
  parameter int MODE     = 0,
  parameter int HOLD_MAX = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 gate_en,
  input  logic [N-1:0]         req,
  input  logic                 release_grant,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_id,
  output logic                 busy,
  output logic                 timeout,
  output logic [7:0]           timeout_cnt
);

  localparam int IDW = $clog2(N);
  localparam int HW  = $clog2(HOLD_MAX + 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  logic [0:0]     state;
  logic [HW-1:0]  hold;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] win;
  logic [N-1:0]   win_oh;
  logic           found;
  int             k;

  // Scan order starts just past the last winner in round-robin mode.
  always_comb begin
    win   = '0;
    found = 1'b0;
    k     = 0;
    for (int i = 0; i < N; i++) begin
      k = (MODE == 1) ? (int'(rr_ptr) + 1 + i) % N : i;
      if (!found && req[k[IDW-1:0]]) begin
        win   = k[IDW-1:0];
        found = 1'b1;
      end
    end
  end

  always_comb begin
    win_oh      = '0;
    win_oh[win] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      grant       <= '0;
      grant_id    <= '0;
      busy        <= 1'b0;
      timeout     <= 1'b0;
      timeout_cnt <= '0;
      hold        <= '0;
      rr_ptr      <= IDW'(N - 1);
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (gate_en && found) begin
            state    <= GRANT;
            grant    <= win_oh;
            grant_id <= win;
            busy     <= 1'b1;
            hold     <= '0;
            rr_ptr   <= win;
          end
        end
        GRANT: begin
          hold <= hold + HW'(1);
          if (!gate_en || release_grant || !req[grant_id]) begin
            state <= IDLE;
            grant <= '0;
            busy  <= 1'b0;
          end else if (hold == HW'(HOLD_MAX - 1)) begin
            state   <= IDLE;
            grant   <= '0;
            busy    <= 1'b0;
            timeout <= 1'b1;
            if (timeout_cnt != 8'hFF)
              timeout_cnt <= timeout_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
